// File: rtl/mpadd_ctrl_pkg.sv
// Shared constants for the word-serial multi-precision adder: word width,
// default operand size and the controller state encoding.
package mpadd_ctrl_pkg;

    localparam int WORD_W     = 32;
    localparam int NWORDS_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mpadd_ctrl_add32.sv
// Single 32-bit adder slice shared by every word of a multi-precision operation.
// Outputs are forced to zero whenever the add strobe is low.
module mpadd_ctrl_add32
    import mpadd_ctrl_pkg::*;
(
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              add,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W:0] total;
    logic            unused_clk_rst;

    // Purely combinational today; clock and reset stay on the port list so a
    // pipelined slice can drop in without touching the controller.
    assign unused_clk_rst = m_clock ^ p_reset;

    always_comb begin
        total = '0;
        if (add) begin
            total = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
        end
    end

    assign sum  = total[WORD_W-1:0];
    assign cout = total[WORD_W];

endmodule

// File: rtl/mpadd_ctrl.sv
// Word-serial W-bit add/subtract controller: one 32-bit word per cycle,
// least-significant word first, through a single shared adder slice.
module mpadd_ctrl
    import mpadd_ctrl_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic                     m_clock,
    input  logic                     p_reset,
    input  logic                     start,
    input  logic                     sub,
    input  logic [WORD_W*NWORDS-1:0] a,
    input  logic [WORD_W*NWORDS-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [WORD_W*NWORDS-1:0] result,
    output logic                     cout,
    output logic                     ov
);

    localparam int W  = WORD_W * NWORDS;
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ov_q, ov_d;

    int                word_lsb;
    logic              add;
    logic [WORD_W-1:0] add_a, add_b, add_sum;
    logic              add_cout;
    logic              a_top, bp_top, r_top;

    assign word_lsb = WORD_W * int'(idx_q);
    assign add      = (state_q == ST_RUN);
    assign add_a    = a_q[word_lsb +: WORD_W];
    assign add_b    = b_q[word_lsb +: WORD_W] ^ {WORD_W{sub_q}};

    mpadd_ctrl_add32 u_add32 (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .add     (add),
        .a       (add_a),
        .b       (add_b),
        .cin     (carry_q),
        .sum     (add_sum),
        .cout    (add_cout)
    );

    // Sign bits of the top word feed the signed-overflow flag.
    assign a_top  = a_q[W-1];
    assign bp_top = b_q[W-1] ^ sub_q;
    assign r_top  = add_sum[WORD_W-1];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ov_d     = ov_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub;
                end
            end
            ST_RUN: begin
                result_d[word_lsb +: WORD_W] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    cout_d  = add_cout;
                    ov_d    = (~a_top & ~bp_top & r_top) | (a_top & bp_top & ~r_top);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ov_q     <= ov_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ov     = ov_q;

endmodule

// File: tb/tb_mpadd_ctrl.sv
// Self-checking bench for mpadd_ctrl: directed corner cases, random operations
// against an arithmetic reference model, ignored starts, mid-run reset, back-to-back.
module tb_mpadd_ctrl;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic         m_clock = 1'b0;
    logic         p_reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ov;

    int checks = 0;
    int fails  = 0;

    always #5 m_clock = ~m_clock;

    mpadd_ctrl #(.NWORDS(NW)) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .ov      (ov)
    );

    // Reference model: plain W-bit arithmetic on whole operands.
    function automatic logic [W-1:0] exp_result(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        return s ? (x - y) : (x + y);
    endfunction

    function automatic logic exp_cout(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y};
        return s ? (x >= y) : full[W];
    endfunction

    function automatic logic exp_ov(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] r;
        r = exp_result(x, y, s);
        if (s) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Launch one operation from IDLE and wait for done; lat = cycles from the
    // accepting edge to done, or -1 if done never arrives.
    task automatic issue_and_wait(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int lat);
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        @(posedge m_clock);
        #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge m_clock);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        p_reset = 1'b1;
        start = 1'b1;
        sub = 1'b0;
        a = '1;
        b = '1;
        repeat (2) @(posedge m_clock);
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin fails++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        checks++; if (cout !== 1'b0) begin fails++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (ov !== 1'b0) begin fails++; $display("[TB] FAIL reset_ov: got %b expected 0", ov); end
        start = 1'b0;
        p_reset = 1'b0;
        @(posedge m_clock);
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4], tb_v[4], tr[4];
        logic         ts[4], tc[4], tv[4];
        int           lat;
        ta[0] = 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF; tb_v[0] = 128'd1; ts[0] = 1'b0;
        tr[0] = 128'h00000001_00000000_00000000_00000000; tc[0] = 1'b0; tv[0] = 1'b0;
        ta[1] = '0;                                       tb_v[1] = 128'd1; ts[1] = 1'b1;
        tr[1] = '1;                                       tc[1] = 1'b0; tv[1] = 1'b0;
        ta[2] = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF; tb_v[2] = 128'd1; ts[2] = 1'b0;
        tr[2] = 128'h80000000_00000000_00000000_00000000; tc[2] = 1'b0; tv[2] = 1'b1;
        ta[3] = 128'h80000000_00000000_00000000_00000000; tb_v[3] = 128'd1; ts[3] = 1'b1;
        tr[3] = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF; tc[3] = 1'b1; tv[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_and_wait(ta[i], tb_v[i], ts[i], lat);
            checks++; if (lat != NW) begin fails++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, NW); end
            checks++; if (result !== tr[i]) begin fails++; $display("[TB] FAIL dir%0d_result: got %h expected %h", i, result, tr[i]); end
            checks++; if (cout !== tc[i]) begin fails++; $display("[TB] FAIL dir%0d_cout: got %b expected %b", i, cout, tc[i]); end
            checks++; if (ov !== tv[i]) begin fails++; $display("[TB] FAIL dir%0d_ov: got %b expected %b", i, ov, tv[i]); end
            checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL dir%0d_busy_in_done: got %b expected 1", i, busy); end
            @(posedge m_clock);
            #1;
            checks++; if ({done, busy} !== 2'b00) begin fails++; $display("[TB] FAIL dir%0d_after_done: got done,busy=%b expected 00", i, {done, busy}); end
            checks++; if (result !== tr[i]) begin fails++; $display("[TB] FAIL dir%0d_result_held: got %h expected %h", i, result, tr[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic         s;
        int           lat;
        for (int i = 0; i < 20; i++) begin
            x = rand_operand();
            y = rand_operand();
            s = 1'($urandom_range(0, 1));
            issue_and_wait(x, y, s, lat);
            checks++; if (lat != NW) begin fails++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", i, lat, NW); end
            checks++; if (result !== exp_result(x, y, s)) begin fails++; $display("[TB] FAIL rnd%0d_result: got %h expected %h", i, result, exp_result(x, y, s)); end
            checks++; if (cout !== exp_cout(x, y, s)) begin fails++; $display("[TB] FAIL rnd%0d_cout: got %b expected %b", i, cout, exp_cout(x, y, s)); end
            checks++; if (ov !== exp_ov(x, y, s)) begin fails++; $display("[TB] FAIL rnd%0d_ov: got %b expected %b", i, ov, exp_ov(x, y, s)); end
            @(posedge m_clock);
            #1;
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] x, y, got;
        logic         s, gc, gv;
        int           ndone;
        x = rand_operand();
        y = rand_operand();
        s = 1'b0;
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        @(posedge m_clock);
        #1;
        ndone = 0;
        got = '0;
        gc = 1'b0;
        gv = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (busy) begin
                start = 1'b1;
                a = rand_operand();
                b = rand_operand();
                sub = ~s;
            end else begin
                start = 1'b0;
            end
            @(posedge m_clock);
            #1;
            if (done) begin
                ndone++;
                got = result;
                gc = cout;
                gv = ov;
            end
        end
        start = 1'b0;
        checks++; if (ndone != 1) begin fails++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (got !== exp_result(x, y, s)) begin fails++; $display("[TB] FAIL ignore_result: got %h expected %h", got, exp_result(x, y, s)); end
        checks++; if (gc !== exp_cout(x, y, s)) begin fails++; $display("[TB] FAIL ignore_cout: got %b expected %b", gc, exp_cout(x, y, s)); end
        checks++; if (gv !== exp_ov(x, y, s)) begin fails++; $display("[TB] FAIL ignore_ov: got %b expected %b", gv, exp_ov(x, y, s)); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_idle_after: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        int lat;
        a = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        b = 128'h11111111_22222222_33333333_44444444;
        sub = 1'b0;
        start = 1'b1;
        @(posedge m_clock);
        #1;
        start = 1'b0;
        @(posedge m_clock);
        #1;
        p_reset = 1'b1;
        @(posedge m_clock);
        #1;
        p_reset = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (result !== '0) begin fails++; $display("[TB] FAIL midrst_result: got %h expected 0", result); end
        checks++; if ({cout, ov} !== 2'b00) begin fails++; $display("[TB] FAIL midrst_flags: got cout,ov=%b expected 00", {cout, ov}); end
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge m_clock);
            #1;
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin fails++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", ndone); end
        issue_and_wait(128'd5, 128'd7, 1'b0, lat);
        checks++; if (lat != NW) begin fails++; $display("[TB] FAIL midrst_new_latency: got %0d expected %0d", lat, NW); end
        checks++; if (result !== 128'd12) begin fails++; $display("[TB] FAIL midrst_new_result: got %h expected %h", result, 128'd12); end
        @(posedge m_clock);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$], qb[$];
        logic         qs[$];
        logic [W-1:0] x, y;
        logic         s;
        int           ndone, last;
        x = rand_operand(); y = rand_operand(); s = 1'($urandom_range(0, 1));
        qa.push_back(x); qb.push_back(y); qs.push_back(s);
        a = x; b = y; sub = s;
        start = 1'b1;
        ndone = 0;
        last = -1;
        for (int cyc = 0; cyc < 80 && ndone < 5; cyc++) begin
            @(posedge m_clock);
            #1;
            if (done) begin
                ndone++;
                x = qa.pop_front(); y = qb.pop_front(); s = qs.pop_front();
                checks++; if (result !== exp_result(x, y, s)) begin fails++; $display("[TB] FAIL b2b%0d_result: got %h expected %h", ndone, result, exp_result(x, y, s)); end
                checks++; if ({cout, ov} !== {exp_cout(x, y, s), exp_ov(x, y, s)}) begin fails++; $display("[TB] FAIL b2b%0d_flags: got cout,ov=%b expected %b", ndone, {cout, ov}, {exp_cout(x, y, s), exp_ov(x, y, s)}); end
                if (last >= 0) begin
                    checks++; if (cyc - last != NW + 2) begin fails++; $display("[TB] FAIL b2b%0d_period: got %0d expected %0d", ndone, cyc - last, NW + 2); end
                end
                last = cyc;
                x = rand_operand(); y = rand_operand(); s = 1'($urandom_range(0, 1));
                qa.push_back(x); qb.push_back(y); qs.push_back(s);
                a = x; b = y; sub = s;
            end
        end
        start = 1'b0;
        checks++; if (ndone != 5) begin fails++; $display("[TB] FAIL b2b_done_count: got %0d expected 5", ndone); end
        repeat (2) @(posedge m_clock);
        #1;
    endtask

    initial begin
        p_reset = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mpadd_ctrl.md
MPADD_CTRL -- requirements
Module: mpadd_ctrl

Interface
REQ-001 Parameter: NWORDS, default 4, number of 32-bit words per operand (operand width W = 32*NWORDS, NWORDS >= 2).
REQ-002 Port: m_clock  in  1  single clock; all state changes on rising edge.
REQ-003 Port: p_reset  in  1  reset, synchronous and active-high.
REQ-004 Port: start  in  1  request a W-bit operation; sampled only in IDLE.
REQ-005 Port: sub  in  1  0 = A+B, 1 = A-B; latched with start.
REQ-006 Port: a  in  W  operand A; latched with start.
REQ-007 Port: b  in  W  operand B; latched with start.
REQ-008 Port: busy  out  1  high in RUN and DONE.
REQ-009 Port: done  out  1  one-cycle pulse; result valid.
REQ-010 Port: result  out  W  sum/difference; held from done until the next accepted start.
REQ-011 Port: cout  out  1  carry out of bit W-1 (sub: 1 = no borrow).
REQ-012 Port: ov  out  1  two's-complement signed overflow of the W-bit operation.

Function
REQ-013 States: IDLE, RUN, DONE. IDLE->RUN on start; RUN->DONE after the last word; DONE->IDLE unconditionally after 1 cycle.
REQ-014 Accept rule: start=1 in IDLE latches a, b and sub, clears the word index to 0, and loads the carry register with sub.
REQ-015 start in RUN or DONE is ignored; no queueing.
REQ-016 RUN, word i (i = 0..NWORDS-1, LSW first), one cycle per word: adder operands are A[32i+31:32i], B' word and the carry register.
REQ-017 B' = B when sub=0, ~B when sub=1.
REQ-018 End of each RUN cycle: sum word written to result[32i+31:32i]; adder carry-out written to the carry register; index incremented.
REQ-019 Latency: start accepted at edge T; RUN occupies cycles T..T+NWORDS-1; done=1 during cycle T+NWORDS.
REQ-020 Total occupancy is NWORDS+1 cycles; the next start is accepted at the earliest in the following IDLE cycle.
REQ-021 cout = carry register after the last word; valid in DONE and held afterwards.
REQ-022 ov = (~a[W-1] & ~b'[W-1] & r[W-1]) | (a[W-1] & b'[W-1] & ~r[W-1]), where r is result; computed from the top word; valid in DONE and held.
REQ-023 Adder strobe (add) is high only in RUN; adder inputs are don't-care otherwise.
REQ-024 Index wrap: the index never exceeds NWORDS-1. RUN->DONE is taken when the index equals NWORDS-1.
REQ-025 result, cout and ov remain stable through IDLE until the next accepted start.
REQ-026 Partial words of result may change during RUN; consumers sample them only on done.

Reset
REQ-027 p_reset=1 at a clock edge forces state IDLE, index 0, carry register 0, busy 0, done 0, result 0, cout 0, ov 0.
REQ-028 Reset mid-RUN or in DONE aborts the operation; no done pulse follows.
REQ-029 Reset has priority over start in the same cycle.

Structure
REQ-030 Shared package: NWORDS default, word width constant 32, state encoding (IDLE/RUN/DONE).
REQ-031 One sub-module: a single add32 instance (a, b, cin, sum, cout, add strobe) as the only arithmetic resource; no additional adders.
REQ-032 Clock and reset ports of the add32 instance are wired directly from m_clock and p_reset.

Verification
REQ-033 NWORDS=4, add: A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1 -> result=0x00000001_00000000_00000000_00000000, cout=0, ov=0, done exactly 4 cycles after the start edge.
REQ-034 Sub: A=0, B=1 -> result all-ones (0xFFFF...FFFF), cout=0, ov=0.
REQ-035 Overflow: A=0x7FFF...FFFF, B=1, add -> result=0x8000...0000, ov=1, cout=0. Sub: A=0x8000...0000, B=1 -> result=0x7FFF...FFFF, ov=1, cout=1.
REQ-036 Start pulsed during RUN and during DONE with different operands -> ignored; exactly one done pulse; result matches the first operands.
REQ-037 p_reset asserted in the 2nd RUN cycle -> next cycle busy=0, result=0; no done pulse. A new start afterwards completes correctly (e.g. 5+7 -> 12).
REQ-038 Back-to-back: start held high continuously -> operations complete every NWORDS+2 cycles, each with a correct result.
